lab61soc_button_ctrl: RTL and testbench
=======================================

Name: lab61soc_button_ctrl

Overview:
- Avalon-MM slave controller for the board push-button inputs.
- Synchronizes and debounces each button, captures press edges into sticky flags, and raises a maskable interrupt to the Nios II.
- Sits between the raw in_port pins and the system interconnect.
- Register map: 0 = debounced level, 1 = reads 0, 2 = interrupt mask, 3 = edge capture.

Parameters:
- WIDTH, 2, number of button inputs (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced level changes (10 ms at 50 MHz); minimum 2.
- EDGE_TYPE, 0, capture edge: 0 = falling (press, active-low buttons), 1 = rising, 2 = either.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- in_port  in  WIDTH  raw button pins, asynchronous, active-low.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - readdata = 0, irq = 0, mask = 0, edgecapture = 0.
  - Synchronizer flops and debounced level reset to all ones (released).
  - Debounce counters reset to 0.
- Synchronizer: two flops per bit on in_port. Raw-to-synchronized latency is 2 cycles.
- Debounce, per bit, using a counter of width clog2(DEBOUNCE_CYCLES):
  - If the synchronized bit equals the debounced bit: counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced bit takes the synchronized value and the counter clears the same cycle.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the debounced bit.
  - Bits are independent.
- Edge detect: a delayed copy of the debounced level is kept. A per-bit edge pulse fires for exactly one cycle when the debounced level changes in the direction selected by EDGE_TYPE.
- Edge capture (address 3):
  - Set by an edge pulse; sticky.
  - Cleared by a write with chipselect=1, write_n=0, address=3, write-1-to-clear per bit.
  - If set and clear hit the same bit in the same cycle, set wins.
- Mask (address 2): written from writedata[WIDTH-1:0]; upper bits ignored.
- Writes to addresses 0 and 1 are ignored.
- Reads:
  - readdata is updated every cycle from the address mux: 0 → debounced level, 1 → 0, 2 → mask, 3 → edgecapture.
  - Zero-extended to 32 bits; 1-cycle read latency.
  - No dependency on chipselect, so reads have no side effects.
- irq = OR-reduction of (edgecapture & mask), driven from a flop. It rises 1 cycle after the edgecapture bit sets and falls 1 cycle after the clear.
- No wait states; the slave is always ready.

Optional Feature:
- Macro: BUTTON_CTRL_DEBOUNCE_EN.
- Defined: debounce counters present as described above.
- Undefined: counters are removed. The debounced level equals the synchronized level (total 2-cycle latency), and DEBOUNCE_CYCLES is ignored.
- Register map, edge logic and irq timing are identical in both builds.

Decomposition:
- Package lab61soc_button_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3;
  - EDGE_FALL/EDGE_RISE/EDGE_ANY encodings;
  - a clog2-based counter-width function.
- One natural sub-module, lab61soc_button_debounce: a single-bit synchronizer plus debouncer, instantiated WIDTH times via generate.
- The top level holds the edge, mask, irq and read-mux logic.

Test Plan:
1. Reset with in_port=2'b11, then read address 0 → readdata=32'h3; read address 3 → 0; irq=0.
2. Drive in_port[0]=0 for 100 cycles with DEBOUNCE_CYCLES=8 → address 0 reads 32'h2 starting exactly 2+8 cycles after the input change (registered readdata adds 1 cycle); address 3 reads 32'h1.
3. Glitch in_port[1] low for 5 cycles with DEBOUNCE_CYCLES=8 → address 0 stays 32'h3; edgecapture stays 0.
4. Write mask=32'h1, then press bit 0 → irq goes 1 one cycle after edgecapture[0] sets. Write 32'h1 to address 3 → edgecapture=0, irq falls the next cycle.
5. Press bit 1 in the same cycle as a W1C write of 32'h2 to address 3 → edgecapture[1] remains 1.
6. Assert reset_n=0 mid-debounce (counter at 4) → all outputs return to reset values immediately. After release, no edge is captured while in_port stays high.

Source files
------------

// File: rtl/lab61soc_button_pkg.sv
// -----------------------------------------------------------------------------
// lab61soc_button_pkg
// Shared constants for the push-button controller: Avalon register addresses,
// edge-type encodings and the debounce counter width helper.
// -----------------------------------------------------------------------------
package lab61soc_button_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_ANY  = 2;

    // Width of a counter that must hold values 0 .. cycles-1 (never below 1).
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/lab61soc_button_ctrl_if.sv
// -----------------------------------------------------------------------------
// lab61soc_button_ctrl_if
// Avalon-MM slave bus bundle for the push-button controller.
//   address    : 2-bit word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
// -----------------------------------------------------------------------------
interface lab61soc_button_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lab61soc_button_debounce.sv
// -----------------------------------------------------------------------------
// lab61soc_button_debounce
// Single-bit two-flop synchronizer followed by an optional debouncer.
// Build option: BUTTON_CTRL_DEBOUNCE_EN. When defined, the level only follows
// the synchronized input after it has differed for DEBOUNCE_CYCLES consecutive
// cycles; when undefined, the level is the synchronized input directly.
//   clk     : system clock
//   reset_n : asynchronous active-low reset (level resets to 1 = released)
//   raw     : asynchronous button pin
//   level   : synchronized (and debounced) button level
// -----------------------------------------------------------------------------
module lab61soc_button_debounce
    import lab61soc_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic sync_p0;
    logic sync_p1;

    // stage p0/p1: metastability synchronizer, resets to released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

`ifdef BUTTON_CTRL_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          level_q;

    // stage p2: count consecutive disagreeing cycles; any agreement restarts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            level_q <= 1'b1;
        end else if (sync_p1 == level_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level_q <= sync_p1;
            cnt     <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync_p1;
`endif

endmodule

// File: rtl/lab61soc_button_ctrl.sv
// -----------------------------------------------------------------------------
// lab61soc_button_ctrl
// Avalon-MM push-button controller: per-bit synchronize/debounce, sticky edge
// capture (write-1-to-clear), interrupt mask and a registered level interrupt.
// Build option: BUTTON_CTRL_DEBOUNCE_EN enables the debounce counters inside
// lab61soc_button_debounce; register map and timing are otherwise identical.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port : raw active-low button pins, asynchronous
//   irq     : active-high level interrupt = |(edgecapture & mask), registered
// Register map: 0 level, 1 reads 0, 2 mask, 3 edge capture.
// -----------------------------------------------------------------------------
module lab61soc_button_ctrl
    import lab61soc_button_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    lab61soc_button_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] clr;
    logic             wr;
    logic [31:0]      rd_next;
    logic [31:0]      readdata_q;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        lab61soc_button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (in_port[i]),
            .level  (level[i])
        );
    end

    // Only the low WIDTH bits of writedata are architecturally meaningful.
    assign unused_wdata = ^bus.writedata;

    assign wr  = bus.chipselect && !bus.write_n;
    assign clr = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        edge_pulse = ~level & level_d;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_pulse = level & ~level_d;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_pulse = level ^ level_d;
        end
    end

    // Reads are side-effect free, so the mux ignores chipselect.
    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA: rd_next[WIDTH-1:0] = level;
            ADDR_MASK: rd_next[WIDTH-1:0] = mask;
            ADDR_EDGE: rd_next[WIDTH-1:0] = edge_cap;
            default:   rd_next = '0;
        endcase
    end

    // Set has priority over a same-cycle write-1-to-clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d    <= '1;
            edge_cap   <= '0;
            mask       <= '0;
            irq        <= 1'b0;
            readdata_q <= '0;
        end else begin
            level_d    <= level;
            edge_cap   <= (edge_cap & ~clr) | edge_pulse;
            if (wr && bus.address == ADDR_MASK) begin
                mask <= bus.writedata[WIDTH-1:0];
            end
            irq        <= |(edge_cap & mask);
            readdata_q <= rd_next;
        end
    end

    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_lab61soc_button_ctrl.sv
module tb_lab61soc_button_ctrl;

    localparam int W  = 2;
    localparam int DC = 8;
`ifdef BUTTON_CTRL_DEBOUNCE_EN
    localparam int OFF  = 2;
    localparam int NWIN = DC;
`else
    localparam int OFF  = 1;
    localparam int NWIN = 1;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '1;
    logic         irq;

    lab61soc_button_ctrl_if bus ();

    lab61soc_button_ctrl #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE      (0)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_lvl, m_lvl_prev, m_ec, m_mask;
    logic [W-1:0] hist[$];
    exp_t         sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl      = '1;
        m_lvl_prev = '1;
        m_ec       = '0;
        m_mask     = '0;
        hist.delete();
        for (int i = 0; i < OFF + NWIN; i++) hist.push_back('1);
    endtask

    // One clock edge of the reference model: the debounced bit flips once the
    // pin has shown the opposite value over the whole observation window.
    task automatic model_step();
        exp_t         e;
        logic [W-1:0] pulse, clr, nxt;
        logic         wr;
        bit           stable;
        wr = bus.chipselect && !bus.write_n;
        case (bus.address)
            2'd0:    e.rd = 32'(m_lvl);
            2'd2:    e.rd = 32'(m_mask);
            2'd3:    e.rd = 32'(m_ec);
            default: e.rd = 32'd0;
        endcase
        e.irq = |(m_ec & m_mask);
        pulse = m_lvl_prev & ~m_lvl;
        clr   = (wr && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
        if (wr && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
        m_ec = (m_ec & ~clr) | pulse;
        hist.push_front(in_port);
        void'(hist.pop_back());
        nxt = m_lvl;
        for (int b = 0; b < W; b++) begin
            stable = 1'b1;
            for (int i = OFF; i < OFF + NWIN; i++)
                if (hist[i][b] == m_lvl[b]) stable = 1'b0;
            if (stable) nxt[b] = ~m_lvl[b];
        end
        m_lvl_prev = m_lvl;
        m_lvl      = nxt;
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
                sb.delete();
            end else begin
                model_step();
            end
        end
    end

    // Monitor: outputs are registered, so compare once per cycle at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_readdata", bus.readdata, 32'd0);
                check("reset_irq", 32'(irq), 32'd0);
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                check("readdata", bus.readdata, e.rd);
                check("irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        int hold;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        in_port        = '1;
        idle(3);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Idle after reset: level reads 3, edge capture 0
        bus.address = 2'd0;  idle(4);
        bus.address = 2'd3;  idle(3);

        // Long press of bit 0
        in_port = 2'b10;
        bus.address = 2'd0;  idle(50);
        bus.address = 2'd3;  idle(50);
        bus.address = 2'd1;  idle(3);
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        bus.address = 2'd0;
        in_port = 2'b11;     idle(20);
        wr(2'd3, 32'h1);
        bus.address = 2'd3;  idle(3);

        // Short glitch on bit 1
        in_port = 2'b01;     idle(5);
        in_port = 2'b11;
        bus.address = 2'd0;  idle(10);
        bus.address = 2'd3;  idle(10);

        // Masked interrupt on bit 0, then clear
        wr(2'd2, 32'h1);
        bus.address = 2'd3;
        in_port = 2'b10;     idle(30);
        wr(2'd3, 32'h1);
        idle(5);
        in_port = 2'b11;     idle(20);

        // Bit 1 edge lands in the same cycle as its W1C write
        wr(2'd2, 32'h3);
        in_port = 2'b01;
        idle(OFF + NWIN);
        wr(2'd3, 32'h2);
        bus.address = 2'd3;  idle(10);
        in_port = 2'b11;     idle(20);

        // Asynchronous reset part-way through a debounce
        bus.address = 2'd0;
        in_port = 2'b10;
        idle(OFF + 4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        in_port = 2'b11;
        #1;
        check("async_reset_readdata", bus.readdata, 32'd0);
        check("async_reset_irq", 32'(irq), 32'd0);
        idle(2);
        @(posedge clk);
        #2 reset_n = 1'b1;
        bus.address = 2'd3;  idle(30);

        // Randomized traffic
        hold = 0;
        for (int k = 0; k < 1500; k++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold = $urandom_range(1, 20);
            end
            hold--;
            bus.address    = 2'($urandom_range(0, 3));
            bus.chipselect = ($urandom_range(0, 3) == 0);
            bus.write_n    = 1'($urandom_range(0, 1));
            bus.writedata  = $urandom;
            @(negedge clk);
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
